// File: rtl/wall_renderer.sv
// wall_renderer
//   Column-buffer renderer for a ray-cast wall display. A tracer writes one
//   {side, half-height} entry per screen column; the VGA scan reads the entry
//   of the current column and decides, per pixel, whether it lies on the wall
//   slice centred on MID_ROW, producing a 6-bit colour two cycles later.
//   After reset the buffer is swept to zero (CLEAR) before RUN begins.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   store      tracer write strobe (one entry per cycle while high)
//   column     write column index
//   side       wall side to store (0 = X-side, 1 = Y-side)
//   height     wall half-height to store, in rows
//   h, v       current VGA horizontal / vertical position
//   visible    (h,v) lies in the active display area
//   ready      clear sweep finished, block in RUN
//   wall       pixel lies on a wall
//   wall_side  stored side of the wall pixel, 0 when wall=0
//   rgb        pixel colour {R[1:0],G[1:0],B[1:0]}
module wall_renderer #(
  parameter int COLS    = 640,
  parameter int MID_ROW = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       store,
  input  logic [9:0] column,
  input  logic       side,
  input  logic [7:0] height,
  input  logic [9:0] h,
  input  logic [9:0] v,
  input  logic       visible,
  output logic       ready,
  output logic       wall,
  output logic       wall_side,
  output logic [5:0] rgb
);

  localparam logic [10:0] COLS_W    = 11'(COLS);
  localparam logic [9:0]  LAST_ADDR = 10'(COLS - 1);
  localparam logic [10:0] MID_W     = 11'(MID_ROW);

  localparam logic [5:0] RGB_WALL_X  = 6'b110000;
  localparam logic [5:0] RGB_WALL_Y  = 6'b100000;
  localparam logic [5:0] RGB_CEILING = 6'b010101;
  localparam logic [5:0] RGB_FLOOR   = 6'b101010;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t     state_q, state_d;
  logic [9:0] clr_addr_q, clr_addr_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      if (clr_addr_q == LAST_ADDR) begin
        state_d    = ST_RUN;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + 10'd1;
      end
    end
  end

  assign ready = (state_q == ST_RUN);

  // ---------------------------------------------------------- write port
  // The sweep owns the write port during CLEAR, so tracer stores are dropped.
  logic       we;
  logic [9:0] waddr;
  logic [8:0] wdata;
  logic [9:0] raddr;

  always_comb begin
    we    = 1'b0;
    waddr = clr_addr_q;
    wdata = '0;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        we = 1'b1;
      end else if (store && ({1'b0, column} < COLS_W)) begin
        we    = 1'b1;
        waddr = column;
        wdata = {side, height};
      end
    end
  end

  // Off-screen columns read entry 0 rather than indexing past the buffer.
  assign raddr = ({1'b0, h} < COLS_W) ? h : '0;

  // ---------------------------------------------------------- storage
  // Single process with non-blocking read gives read-before-write on a
  // same-address collision.
  logic [8:0] mem [COLS];
  logic [8:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_data_q <= mem[raddr];
  end

  // ---------------------------------------------------------- stage 1
  logic [9:0] v_s1_q, v_s1_d;
  logic       vis_s1_q, vis_s1_d;

  assign v_s1_d   = v;
  assign vis_s1_d = visible;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_s1_q   <= '0;
      vis_s1_q <= 1'b0;
    end else begin
      v_s1_q   <= v_s1_d;
      vis_s1_q <= vis_s1_d;
    end
  end

  // ---------------------------------------------------------- stage 2
  logic [10:0] h_ext, lo_bound, hi_bound, v_ext;
  logic        hit;
  logic        wall_q, wall_d;
  logic        wall_side_q, wall_side_d;
  logic [5:0]  rgb_q, rgb_d;

  always_comb begin
    h_ext    = {3'b000, rd_data_q[7:0]};
    v_ext    = {1'b0, v_s1_q};
    // Tall walls would underflow the top edge; clamp to row 0 instead.
    lo_bound = (h_ext > MID_W) ? 11'd0 : (MID_W - h_ext);
    hi_bound = MID_W + h_ext;
    hit      = vis_s1_q && (h_ext != 11'd0) && (v_ext >= lo_bound) && (v_ext < hi_bound);

    wall_d      = 1'b0;
    wall_side_d = 1'b0;
    rgb_d       = 6'b000000;
    if (state_q == ST_RUN && vis_s1_q) begin
      if (hit) begin
        wall_d      = 1'b1;
        wall_side_d = rd_data_q[8];
        rgb_d       = rd_data_q[8] ? RGB_WALL_Y : RGB_WALL_X;
      end else begin
        rgb_d = (v_ext < MID_W) ? RGB_CEILING : RGB_FLOOR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wall_q      <= 1'b0;
      wall_side_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      wall_q      <= wall_d;
      wall_side_q <= wall_side_d;
      rgb_q       <= rgb_d;
    end
  end

  assign wall      = wall_q;
  assign wall_side = wall_side_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_wall_renderer.sv
// Directed testbench for wall_renderer: clear sweep timing, wall slice
// geometry, saturation, out-of-range writes, read/write collision,
// blanking and reset during RUN.
module tb_wall_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic       store;
  logic [9:0] column;
  logic       side;
  logic [7:0] height;
  logic [9:0] h;
  logic [9:0] v;
  logic       visible;
  logic       ready;
  logic       wall;
  logic       wall_side;
  logic [5:0] rgb;

  int checks = 0;
  int passed = 0;

  wall_renderer #(.COLS(640), .MID_ROW(240)) dut (
    .clk(clk), .reset(reset), .store(store), .column(column), .side(side),
    .height(height), .h(h), .v(v), .visible(visible), .ready(ready),
    .wall(wall), .wall_side(wall_side), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic write_col(input logic [9:0] c, input logic s, input logic [7:0] ht);
    @(negedge clk);
    store = 1'b1; column = c; side = s; height = ht;
    @(posedge clk); #1;
    store = 1'b0;
    $display("write col=%0d side=%0b height=%0d", c, s, ht);
  endtask

  task automatic read_px(input logic [9:0] hh, input logic [9:0] vv, input logic vis);
    @(negedge clk);
    h = hh; v = vv; visible = vis;
    @(posedge clk);
    @(posedge clk); #1;
    $display("read h=%0d v=%0d vis=%0b -> wall=%0b side=%0b rgb=%b", hh, vv, vis, wall, wall_side, rgb);
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1; store = 1'b1; column = 10'd3; side = 1'b1; height = 8'd50;
    h = 10'd3; v = 10'd230; visible = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else passed++;
    checks++; if (wall !== 1'b0) $display("FAIL reset_wall: got %b expected 0", wall); else passed++;
    checks++; if (wall_side !== 1'b0) $display("FAIL reset_wall_side: got %b expected 0", wall_side); else passed++;
    checks++; if (rgb !== 6'b000000) $display("FAIL reset_rgb: got %b expected 000000", rgb); else passed++;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 100) begin
        checks++; if (rgb !== 6'b000000 || wall !== 1'b0) $display("FAIL clear_forces_zero: got rgb=%b wall=%b expected 000000/0", rgb, wall); else passed++;
      end
    end
    store = 1'b0;
    checks++; if (cnt != 640) $display("FAIL clear_cycles: got %0d expected 640", cnt); else passed++;
    $display("clear sweep finished after %0d cycles", cnt);
  endtask

  task automatic test_store_during_clear();
    read_px(10'd3, 10'd230, 1'b1);
    checks++; if (wall !== 1'b0) $display("FAIL dropped_store_wall: got %b expected 0", wall); else passed++;
    checks++; if (rgb !== 6'b010101) $display("FAIL dropped_store_rgb: got %b expected 010101", rgb); else passed++;
  endtask

  task automatic test_wall_column();
    logic [9:0] vs [4];
    logic       we [4];
    logic [5:0] re [4];
    vs[0] = 10'd199; vs[1] = 10'd200; vs[2] = 10'd279; vs[3] = 10'd280;
    we[0] = 1'b0; we[1] = 1'b1; we[2] = 1'b1; we[3] = 1'b0;
    re[0] = 6'b010101; re[1] = 6'b100000; re[2] = 6'b100000; re[3] = 6'b101010;
    write_col(10'd100, 1'b1, 8'd40);
    h = 10'd100; visible = 1'b1;
    // Back-to-back rows, one per cycle; each result appears two edges later.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) v = vs[i];
      @(posedge clk); #1;
      if (i >= 1) begin
        $display("stream v=%0d -> wall=%0b side=%0b rgb=%b", vs[i-1], wall, wall_side, rgb);
        checks++; if (wall !== we[i-1]) $display("FAIL col100_wall_v%0d: got %b expected %b", vs[i-1], wall, we[i-1]); else passed++;
        checks++; if (rgb !== re[i-1]) $display("FAIL col100_rgb_v%0d: got %b expected %b", vs[i-1], rgb, re[i-1]); else passed++;
        checks++; if (wall_side !== we[i-1]) $display("FAIL col100_side_v%0d: got %b expected %b", vs[i-1], wall_side, we[i-1]); else passed++;
      end
    end
  endtask

  task automatic test_saturation();
    write_col(10'd5, 1'b0, 8'd250);
    read_px(10'd5, 10'd0, 1'b1);
    checks++; if (wall !== 1'b1) $display("FAIL sat_v0_wall: got %b expected 1", wall); else passed++;
    checks++; if (rgb !== 6'b110000) $display("FAIL sat_v0_rgb: got %b expected 110000", rgb); else passed++;
    read_px(10'd5, 10'd489, 1'b1);
    checks++; if (wall !== 1'b1) $display("FAIL sat_v489_wall: got %b expected 1", wall); else passed++;
    read_px(10'd5, 10'd490, 1'b1);
    checks++; if (wall !== 1'b0 || rgb !== 6'b101010) $display("FAIL sat_v490: got wall=%b rgb=%b expected 0/101010", wall, rgb); else passed++;
  endtask

  task automatic test_out_of_range();
    write_col(10'd640, 1'b1, 8'd200);
    write_col(10'd1023, 1'b1, 8'd200);
    read_px(10'd0, 10'd150, 1'b1);
    checks++; if (wall !== 1'b0 || rgb !== 6'b010101) $display("FAIL oor_col0: got wall=%b rgb=%b expected 0/010101", wall, rgb); else passed++;
    read_px(10'd128, 10'd150, 1'b1);
    checks++; if (wall !== 1'b0 || rgb !== 6'b010101) $display("FAIL oor_col128: got wall=%b rgb=%b expected 0/010101", wall, rgb); else passed++;
    read_px(10'd383, 10'd150, 1'b1);
    checks++; if (wall !== 1'b0 || rgb !== 6'b010101) $display("FAIL oor_col383: got wall=%b rgb=%b expected 0/010101", wall, rgb); else passed++;
    // h beyond the buffer reads entry 0, which is still empty.
    read_px(10'd640, 10'd150, 1'b1);
    checks++; if (wall !== 1'b0 || rgb !== 6'b010101) $display("FAIL oor_h640: got wall=%b rgb=%b expected 0/010101", wall, rgb); else passed++;
  endtask

  task automatic test_collision();
    @(negedge clk);
    store = 1'b1; column = 10'd7; side = 1'b0; height = 8'd10;
    h = 10'd7; v = 10'd235; visible = 1'b1;
    @(posedge clk); #1;
    store = 1'b0;
    @(posedge clk); #1;
    checks++; if (wall !== 1'b0 || rgb !== 6'b010101) $display("FAIL collision_old: got wall=%b rgb=%b expected 0/010101", wall, rgb); else passed++;
    @(posedge clk); #1;
    checks++; if (wall !== 1'b1 || rgb !== 6'b110000) $display("FAIL collision_new: got wall=%b rgb=%b expected 1/110000", wall, rgb); else passed++;
    checks++; if (wall_side !== 1'b0) $display("FAIL collision_side: got %b expected 0", wall_side); else passed++;
  endtask

  task automatic test_invisible();
    read_px(10'd100, 10'd220, 1'b0);
    checks++; if (rgb !== 6'b000000) $display("FAIL blank_rgb: got %b expected 000000", rgb); else passed++;
    checks++; if (wall !== 1'b0 || wall_side !== 1'b0) $display("FAIL blank_wall: got wall=%b side=%b expected 0/0", wall, wall_side); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int cnt;
    @(negedge clk);
    reset = 1'b1; h = 10'd100; v = 10'd220; visible = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) $display("FAIL midrun_reset_ready: got %b expected 0", ready); else passed++;
    checks++; if (rgb !== 6'b000000) $display("FAIL midrun_reset_rgb: got %b expected 000000", rgb); else passed++;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 320) begin
        checks++; if (rgb !== 6'b000000) $display("FAIL midrun_clear_rgb: got %b expected 000000", rgb); else passed++;
      end
    end
    checks++; if (cnt != 640) $display("FAIL midrun_clear_cycles: got %0d expected 640", cnt); else passed++;
    read_px(10'd100, 10'd220, 1'b1);
    checks++; if (wall !== 1'b0 || rgb !== 6'b010101) $display("FAIL midrun_col100: got wall=%b rgb=%b expected 0/010101", wall, rgb); else passed++;
    read_px(10'd5, 10'd300, 1'b1);
    checks++; if (wall !== 1'b0 || rgb !== 6'b101010) $display("FAIL midrun_col5: got wall=%b rgb=%b expected 0/101010", wall, rgb); else passed++;
    read_px(10'd7, 10'd235, 1'b1);
    checks++; if (wall !== 1'b0 || rgb !== 6'b010101) $display("FAIL midrun_col7: got wall=%b rgb=%b expected 0/010101", wall, rgb); else passed++;
  endtask

  initial begin
    test_reset();
    test_store_during_clear();
    test_wall_column();
    test_saturation();
    test_out_of_range();
    test_collision();
    test_invisible();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
